// File: rtl/mdu_sched_pkg.sv
// Shared types for the MDU issue scheduler: opcodes, result payload, divider FSM states.
package mdu_sched_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROB_W  = 6;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ROB_W-1:0]  rob_id_t;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MOD   = 3'd5,
    OP_MODU  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_HOLD = 2'd2
  } div_state_t;

  typedef struct packed {
    word_t   data;
    rob_id_t rob_id;
  } mdu_res_t;

  // Ops that must go to the iterative divider.
  function automatic logic is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MOD) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/mdu_res_fifo.sv
// Circular result FIFO, one push and one pop per cycle, with occupancy count.
module mdu_res_fifo
  import mdu_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  mdu_res_t               push_data,
  input  logic                   pop,
  output mdu_res_t               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  mdu_res_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             full;

  assign do_pop = pop && (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Credits upstream must make a push into a full queue without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/mdu_sched.sv
// MDU issue controller: steers ops to multiplier/divider, tracks credits, merges results.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned DATA_W    = WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  mdu_op_t           req_op_i,
  input  rob_id_t           req_rob_id_i,
  output mdu_op_t           unit_op_o,
  output logic              mul_valid_o,
  input  logic [DATA_W-1:0] mul_res_i,
  output logic              div_start_o,
  output logic              div_kill_o,
  input  logic              div_done_i,
  input  logic [DATA_W-1:0] div_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output rob_id_t           res_rob_id_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W  = $clog2(RES_DEPTH) + 1;
  localparam int unsigned USED_W = $clog2(RES_DEPTH + MUL_LAT + 2);

  div_state_t                state;
  div_state_t                state_nxt;
  logic [MUL_LAT-1:0]        trk_v;
  rob_id_t [MUL_LAT-1:0]     trk_id;
  rob_id_t                   div_rob;
  word_t                     hold_data;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [USED_W-1:0]         mul_inflight;
  logic [USED_W-1:0]         used;
  logic                      credit_ok;
  logic                      req_is_div;
  logic                      accept;
  logic                      mul_cpl;
  logic                      hold_cap;
  logic                      push;
  logic                      pop;
  mdu_res_t                  push_data;
  mdu_res_t                  head;

  // Credit accounting: everything that will eventually occupy a FIFO slot.
  always_comb begin
    mul_inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      mul_inflight = mul_inflight + USED_W'(trk_v[i]);
    end
    used = USED_W'(fifo_cnt) + mul_inflight + USED_W'(state != DIV_IDLE);
  end

  assign credit_ok  = (used < USED_W'(RES_DEPTH));
  assign req_is_div = is_div(req_op_i);

  // Divider needs an idle FSM; multiplier only blocked while a div result is parked.
  assign req_ready_o = rst_n && credit_ok && !flush &&
                       (req_is_div ? (state == DIV_IDLE) : (state != DIV_HOLD));
  assign accept      = req_valid_i && req_ready_o;
  assign mul_valid_o = accept && !req_is_div;
  assign unit_op_o   = req_op_i;
  assign mul_cpl     = trk_v[MUL_LAT-1];

  // Multiplier in-flight tracker, one stage per cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_v  <= '0;
      trk_id <= '0;
    end else if (flush) begin
      trk_v  <= '0;
    end else begin
      trk_v[0]  <= mul_valid_o;
      trk_id[0] <= req_rob_id_i;
      for (int i = 1; i < MUL_LAT; i++) begin
        trk_v[i]  <= trk_v[i-1];
        trk_id[i] <= trk_id[i-1];
      end
    end
  end

  // Divider FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Divider FSM next state; a mul completion forces a collided div result into HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept && req_is_div) state_nxt = DIV_BUSY;
      DIV_BUSY: if (div_done_i) state_nxt = mul_cpl ? DIV_HOLD : DIV_IDLE;
      DIV_HOLD: if (!mul_cpl) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (flush) begin
      state_nxt = DIV_IDLE;
    end
  end

  // Divider FSM outputs and FIFO write-port arbitration (mul completion has priority).
  always_comb begin
    div_start_o = 1'b0;
    div_kill_o  = 1'b0;
    hold_cap    = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    div_start_o = accept && req_is_div;
    div_kill_o  = flush && (state != DIV_IDLE);
    hold_cap    = (state == DIV_BUSY) && div_done_i && mul_cpl;
    if (mul_cpl) begin
      push      = 1'b1;
      push_data = '{data: word_t'(mul_res_i), rob_id: trk_id[MUL_LAT-1]};
    end else if ((state == DIV_BUSY) && div_done_i) begin
      push      = 1'b1;
      push_data = '{data: word_t'(div_res_i), rob_id: div_rob};
    end else if (state == DIV_HOLD) begin
      push      = 1'b1;
      push_data = '{data: hold_data, rob_id: div_rob};
    end
  end

  // Divider destination id and parked result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_rob   <= '0;
      hold_data <= '0;
    end else if (flush) begin
      hold_data <= '0;
    end else begin
      if (div_start_o) begin
        div_rob <= req_rob_id_i;
      end
      if (hold_cap) begin
        hold_data <= word_t'(div_res_i);
      end
    end
  end

  mdu_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign res_valid_o  = (fifo_cnt != '0);
  assign pop          = res_valid_o && res_ready_i;
  assign res_data_o   = DATA_W'(head.data);
  assign res_rob_id_o = head.rob_id;
  assign busy_o       = (used != '0);

  // A parked div result must never see a new multiplier launch.
  a_hold_blocks_mul: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == DIV_HOLD) && mul_valid_o));

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: vector table, directed corner sequences, random vs. queue model.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  localparam int unsigned MUL_LAT   = 2;
  localparam int unsigned RES_DEPTH = 4;
  localparam int unsigned DATA_W    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              req_valid_i;
  logic              req_ready_o;
  mdu_op_t           req_op_i;
  rob_id_t           req_rob_id_i;
  mdu_op_t           unit_op_o;
  logic              mul_valid_o;
  logic [DATA_W-1:0] mul_res_i;
  logic              div_start_o;
  logic              div_kill_o;
  logic              div_done_i;
  logic [DATA_W-1:0] div_res_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  rob_id_t           res_rob_id_o;
  logic              busy_o;

  mdu_sched #(.MUL_LAT(MUL_LAT), .RES_DEPTH(RES_DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rob_id_i(req_rob_id_i), .unit_op_o(unit_op_o), .mul_valid_o(mul_valid_o),
    .mul_res_i(mul_res_i), .div_start_o(div_start_o), .div_kill_o(div_kill_o),
    .div_done_i(div_done_i), .div_res_i(div_res_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_rob_id_o(res_rob_id_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: whatever was offered at launch time appears MUL_LAT cycles later.
  word_t mul_next;
  word_t mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= mul_next;
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_res_i = mul_pipe[MUL_LAT-1];

  // Reference model: pending multiplies with their due cycle, the result queue, the divider slot.
  typedef struct { int t; word_t data; rob_id_t rob; } mul_ent_t;
  typedef struct { word_t data; rob_id_t rob; } res_ent_t;
  mul_ent_t m_mul[$];
  res_ent_t m_out[$];
  int       m_div;     // 0: no divide, 1: divider running, 2: result parked waiting for port
  rob_id_t  m_drob;
  word_t    m_park;
  int       cyc;

  int       n_tests = 0;
  int       n_fail  = 0;
  logic     last_ready, last_mv, last_rv, last_kill, last_busy;
  rob_id_t  last_rob;
  rob_id_t  seen[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Compare DUT against the model for the current cycle, then advance the model one cycle.
  task automatic model_step();
    int used;
    bit isd, rdy, acc, cpl;
    used = m_out.size() + m_mul.size() + ((m_div != 0) ? 1 : 0);
    isd  = is_div(req_op_i);
    rdy  = (used < int'(RES_DEPTH)) && !flush && (isd ? (m_div == 0) : (m_div != 2));
    acc  = req_valid_i && rdy;
    chk("req_ready", 64'(req_ready_o), 64'(rdy));
    chk("mul_valid", 64'(mul_valid_o), 64'(acc && !isd));
    chk("div_start", 64'(div_start_o), 64'(acc && isd));
    chk("div_kill",  64'(div_kill_o),  64'(flush && (m_div != 0)));
    chk("busy",      64'(busy_o),      64'(used != 0));
    chk("res_valid", 64'(res_valid_o), 64'(m_out.size() != 0));
    chk("unit_op",   64'(unit_op_o),   64'(req_op_i));
    if (m_out.size() != 0) begin
      chk("res_rob",  64'(res_rob_id_o), 64'(m_out[0].rob));
      chk("res_data", 64'(res_data_o),   64'(m_out[0].data));
    end
    last_ready = req_ready_o; last_mv = mul_valid_o; last_rv = res_valid_o;
    last_kill  = div_kill_o;  last_busy = busy_o;    last_rob = res_rob_id_o;
    if (res_valid_o && res_ready_i) seen.push_back(res_rob_id_o);
    if (flush) begin
      m_out.delete(); m_mul.delete(); m_div = 0;
    end else begin
      if (m_out.size() != 0 && res_ready_i) void'(m_out.pop_front());
      cpl = (m_mul.size() != 0) && (m_mul[0].t == cyc);
      if (cpl) begin
        m_out.push_back('{m_mul[0].data, m_mul[0].rob});
        void'(m_mul.pop_front());
      end
      if (m_div == 1 && div_done_i) begin
        if (cpl) begin m_park = div_res_i; m_div = 2; end
        else begin m_out.push_back('{div_res_i, m_drob}); m_div = 0; end
      end else if (m_div == 2 && !cpl) begin
        m_out.push_back('{m_park, m_drob}); m_div = 0;
      end
      if (acc) begin
        if (isd) begin m_div = 1; m_drob = req_rob_id_i; end
        else m_mul.push_back('{cyc + int'(MUL_LAT), mul_next, req_rob_id_i});
      end
    end
    cyc++;
  endtask

  // Drive one cycle of inputs just after the edge, check on the falling edge.
  task automatic step(input int v, input mdu_op_t op, input int rob, input int rr,
                      input int dd, input word_t dres, input int fl);
    req_valid_i  = 1'(v);
    req_op_i     = op;
    req_rob_id_i = rob_id_t'(rob);
    res_ready_i  = 1'(rr);
    div_done_i   = 1'(dd);
    div_res_i    = dres;
    flush        = 1'(fl);
    mul_next     = $urandom();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, OP_MUL, 0, 1, 0, 32'h0, 0);
  endtask

  task automatic check_seen(input string name, input int exp[$]);
    chk({name, "_count"}, 64'(seen.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk($sformatf("%s_order%0d", name, i), 64'(seen[i]), 64'(exp[i]));
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic reset_now();
    req_valid_i = 1'b1; req_op_i = OP_MUL; div_done_i = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 64'(res_valid_o), 64'(0));
    chk("rst_mul_valid", 64'(mul_valid_o), 64'(0));
    chk("rst_div_start", 64'(div_start_o), 64'(0));
    chk("rst_div_kill",  64'(div_kill_o),  64'(0));
    chk("rst_busy",      64'(busy_o),      64'(0));
    m_out.delete(); m_mul.delete(); m_div = 0;
    @(posedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic v; rob_id_t rob; logic rr; logic e_rdy; logic e_mv; logic e_rv; rob_id_t e_rob; } vec_t;
  vec_t tbl[$];

  function automatic void add(input int v, input int rob, input int rr,
                              input int er, input int em, input int erv, input int erob);
    tbl.push_back('{1'(v), rob_id_t'(rob), 1'(rr), 1'(er), 1'(em), 1'(erv), rob_id_t'(erob)});
  endfunction

  initial begin
    rst_n = 1'b1; flush = 1'b0; req_valid_i = 1'b0; req_op_i = OP_MUL; req_rob_id_i = '0;
    div_done_i = 1'b0; div_res_i = '0; res_ready_i = 1'b0; mul_next = '0;
    m_div = 0; m_drob = '0; m_park = '0; cyc = 0;

    // Back-to-back multiplies, writeback always ready.
    add(1,1,1, 1,1,0,0); add(1,2,1, 1,1,0,0); add(1,3,1, 1,1,0,0);
    add(0,0,1, 1,0,1,1); add(0,0,1, 1,0,1,2); add(0,0,1, 1,0,1,3); add(0,0,1, 1,0,0,0);
    // Credit exhaustion with writeback stalled, then release.
    add(1,1,0, 1,1,0,0); add(1,2,0, 1,1,0,0); add(1,3,0, 1,1,0,0); add(1,4,0, 1,1,1,1);
    add(1,5,0, 0,0,1,1); add(1,5,1, 0,0,1,1); add(1,5,0, 1,1,1,2); add(0,0,1, 0,0,1,2);
    add(0,0,1, 1,0,1,3); add(0,0,1, 1,0,1,4); add(0,0,1, 1,0,1,5); add(0,0,1, 1,0,0,0);

    // Power-on reset with a request pending.
    req_valid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("por_res_valid", 64'(res_valid_o), 64'(0));
    chk("por_mul_valid", 64'(mul_valid_o), 64'(0));
    chk("por_div_start", 64'(div_start_o), 64'(0));
    chk("por_busy",      64'(busy_o),      64'(0));
    repeat (2) @(posedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(int'(tbl[i].v), OP_MUL, int'(tbl[i].rob), int'(tbl[i].rr), 0, 32'h0, 0);
      chk($sformatf("tbl%0d_ready", i), 64'(last_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_mulv", i),  64'(last_mv),    64'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_rv", i),    64'(last_rv),    64'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_rob", i), 64'(last_rob), 64'(tbl[i].e_rob));
    end

    // DIV then MUL: multiply overtakes; a second divide waits for the first to finish.
    seen.delete();
    step(1, OP_DIV, 5, 1, 0, 32'h0, 0);
    chk("div_first_ready", 64'(last_ready), 64'(1));
    step(1, OP_MUL, 6, 1, 0, 32'h0, 0);
    for (int k = 0; k < 8; k++) begin
      step(1, OP_DIVU, 7, 1, 0, 32'h0, 0);
      chk("div_second_blocked", 64'(last_ready), 64'(0));
    end
    step(1, OP_DIVU, 7, 1, 1, 32'h0DD0_0005, 0);
    chk("div_blocked_at_done", 64'(last_ready), 64'(0));
    step(1, OP_DIVU, 7, 1, 0, 32'h0, 0);
    chk("div_second_accepted", 64'(last_ready), 64'(1));
    idle(3);
    step(0, OP_MUL, 0, 1, 1, 32'h0DD0_0007, 0);
    idle(3);
    check_seen("div_mul", '{6, 5, 7});

    // Divider finishes in the same cycle a multiply completes.
    seen.delete();
    step(1, OP_DIV, 8, 1, 0, 32'h0, 0);
    idle(2);
    step(1, OP_MUL, 9, 1, 0, 32'h0, 0);
    idle(1);
    step(1, OP_MUL, 10, 1, 1, 32'hC011_0008, 0);
    chk("collide_mul_ready", 64'(last_ready), 64'(1));
    step(1, OP_MUL, 11, 1, 0, 32'h0, 0);
    chk("hold_blocks_mul", 64'(last_ready), 64'(0));
    step(1, OP_MUL, 11, 1, 0, 32'h0, 0);
    chk("after_hold_ready", 64'(last_ready), 64'(1));
    idle(5);
    check_seen("collide", '{9, 8, 10, 11});

    // Flush with the divider busy and two multiplies in flight.
    step(1, OP_DIV, 12, 1, 0, 32'h0, 0);
    step(1, OP_MUL, 13, 1, 0, 32'h0, 0);
    step(1, OP_MUL, 14, 1, 0, 32'h0, 0);
    seen.delete();
    step(1, OP_MUL, 15, 1, 0, 32'h0, 1);
    chk("flush_kill", 64'(last_kill), 64'(1));
    chk("flush_no_accept", 64'(last_ready), 64'(0));
    step(0, OP_MUL, 0, 1, 0, 32'h0, 0);
    chk("post_flush_busy", 64'(last_busy), 64'(0));
    chk("post_flush_ready", 64'(last_ready), 64'(1));
    chk("post_flush_rv", 64'(last_rv), 64'(0));
    idle(4);
    check_seen("flush", '{});

    // Asynchronous reset in the middle of a divide.
    step(1, OP_DIV, 20, 1, 0, 32'h0, 0);
    step(1, OP_MUL, 21, 1, 0, 32'h0, 0);
    reset_now();
    step(0, OP_MUL, 0, 1, 0, 32'h0, 0);
    chk("post_rst_ready", 64'(last_ready), 64'(1));
    chk("post_rst_rv", 64'(last_rv), 64'(0));
    chk("post_rst_busy", 64'(last_busy), 64'(0));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(int'($urandom_range(0, 3) != 0), mdu_op_t'($urandom_range(0, 6)),
           int'($urandom_range(0, 63)), int'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4) == 0), $urandom(), int'($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 20; i++) step(0, OP_MUL, 0, 1, 1, $urandom(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
